// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap sequencer feeding the CSR file
//
// Purpose:
//   Turns a synchronous exception or an MRET from the pipeline into an ordered
//   series of single-register CSR writes, then a one-cycle PC redirect.
//   o_busy stalls the pipeline for the whole sequence.
//
// Ports:
//   i_clk             clock, rising edge
//   i_rst             synchronous reset, active-high
//   i_exc_valid       exception request (wins over i_mret_valid)
//   i_exc_cause[31:0] exception code
//   i_exc_pc[31:0]    PC of the faulting instruction
//   i_exc_tval[31:0]  trap value
//   i_mret_valid      MRET retiring
//   i_mtvec[31:0]     current mtvec (direct mode only)
//   i_mepc[31:0]      current mepc
//   i_mstatus[31:0]   current mstatus
//   o_csr_we          CSR write strobe
//   o_csr_waddr[11:0] CSR write address
//   o_csr_wdata[31:0] CSR write data
//   o_redirect_valid  one-cycle redirect pulse
//   o_redirect_pc     redirect target
//   o_busy            sequence in progress

module trap_ctrl #(
  parameter logic [11:0] MSTATUS_ADDR = 12'h300,
  parameter logic [11:0] MEPC_ADDR    = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR  = 12'h342,
  parameter logic [11:0] MTVAL_ADDR   = 12'h343
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_exc_valid,
  input  logic [31:0] i_exc_cause,
  input  logic [31:0] i_exc_pc,
  input  logic [31:0] i_exc_tval,
  input  logic        i_mret_valid,
  input  logic [31:0] i_mtvec,
  input  logic [31:0] i_mepc,
  input  logic [31:0] i_mstatus,
  output logic        o_csr_we,
  output logic [11:0] o_csr_waddr,
  output logic [31:0] o_csr_wdata,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  output logic        o_busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] W_EPC   = 3'd1;
  localparam logic [2:0] W_CAUSE = 3'd2;
  localparam logic [2:0] W_TVAL  = 3'd3;
  localparam logic [2:0] W_STAT  = 3'd4;
  localparam logic [2:0] M_STAT  = 3'd5;
  localparam logic [2:0] REDIR   = 3'd6;

  // r_state is the state whose outputs are currently on the pins; outputs are
  // computed from the next state and registered alongside it, so the first
  // write appears in the cycle right after acceptance.
  logic [2:0]  r_state;
  logic [31:0] r_cause;
  logic [31:0] r_tval;

  logic [2:0]  w_next;
  logic        w_accept_exc;
  logic        w_we;
  logic [11:0] w_waddr;
  logic [31:0] w_wdata;
  logic        w_rv;
  logic [31:0] w_rpc;
  logic [31:0] w_mstatus_trap;
  logic [31:0] w_mstatus_mret;

  // Low bits of the PC-like inputs are architecturally zero for this block.
  logic w_unused;
  assign w_unused = ^{i_exc_pc[1:0], i_mtvec[1:0], i_mepc[1:0]};

  assign w_accept_exc = (r_state == IDLE) && i_exc_valid;

  // Trap entry: MPIE<=MIE, MIE<=0, MPP<=M; everything else passes through.
  always_comb begin
    w_mstatus_trap        = i_mstatus;
    w_mstatus_trap[7]     = i_mstatus[3];
    w_mstatus_trap[3]     = 1'b0;
    w_mstatus_trap[12:11] = 2'b11;
  end

  // Trap return: MIE<=MPIE, MPIE<=1, MPP<=M.
  always_comb begin
    w_mstatus_mret        = i_mstatus;
    w_mstatus_mret[3]     = i_mstatus[7];
    w_mstatus_mret[7]     = 1'b1;
    w_mstatus_mret[12:11] = 2'b11;
  end

  // Requests are only looked at in IDLE; exception has priority over MRET.
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE: begin
        if (i_exc_valid)       w_next = W_EPC;
        else if (i_mret_valid) w_next = M_STAT;
        else                   w_next = IDLE;
      end
      W_EPC:   w_next = W_CAUSE;
      W_CAUSE: w_next = W_TVAL;
      W_TVAL:  w_next = W_STAT;
      W_STAT:  w_next = REDIR;
      M_STAT:  w_next = REDIR;
      REDIR:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output values for the cycle in which w_next becomes current.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = 12'h000;
    w_wdata = 32'h0000_0000;
    w_rv    = 1'b0;
    w_rpc   = 32'h0000_0000;
    case (w_next)
      W_EPC: begin
        // Only reachable straight from IDLE, so the pipeline PC is still valid.
        w_we    = 1'b1;
        w_waddr = MEPC_ADDR;
        w_wdata = {i_exc_pc[31:2], 2'b00};
      end
      W_CAUSE: begin
        w_we    = 1'b1;
        w_waddr = MCAUSE_ADDR;
        w_wdata = r_cause;
      end
      W_TVAL: begin
        w_we    = 1'b1;
        w_waddr = MTVAL_ADDR;
        w_wdata = r_tval;
      end
      W_STAT: begin
        w_we    = 1'b1;
        w_waddr = MSTATUS_ADDR;
        w_wdata = w_mstatus_trap;
      end
      M_STAT: begin
        w_we    = 1'b1;
        w_waddr = MSTATUS_ADDR;
        w_wdata = w_mstatus_mret;
      end
      REDIR: begin
        // Coming from M_STAT means MRET; mepc is read after the mstatus write
        // has had a cycle to settle in the CSR file.
        w_rv = 1'b1;
        if (r_state == M_STAT) w_rpc = {i_mepc[31:2], 2'b00};
        else                   w_rpc = {i_mtvec[31:2], 2'b00};
      end
      default: begin
        w_we = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= IDLE;
      r_cause          <= 32'h0000_0000;
      r_tval           <= 32'h0000_0000;
      o_csr_we         <= 1'b0;
      o_csr_waddr      <= 12'h000;
      o_csr_wdata      <= 32'h0000_0000;
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= 32'h0000_0000;
      o_busy           <= 1'b0;
    end else begin
      r_state          <= w_next;
      if (w_accept_exc) begin
        r_cause <= i_exc_cause;
        r_tval  <= i_exc_tval;
      end
      o_csr_we         <= w_we;
      o_csr_waddr      <= w_waddr;
      o_csr_wdata      <= w_wdata;
      o_redirect_valid <= w_rv;
      o_redirect_pc    <= w_rpc;
      o_busy           <= (w_next != IDLE);
    end
  end

endmodule
